// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencer for the multi-cycle 16x16 multiplier in the EX stage, with pipeline stall and HI/LO capture
// Ports: clk, rst (async, active-high); start/is_signed/op_a/op_b request in;
//   mul_a/mul_b magnitudes to the multiplier; mul_result/mul_valid back from it;
//   stall (combinational), busy (registered WAIT flag), done (capture pulse), hi/lo product,
//   error (timeout pulse). Timeout is compiled in with `define MULT_TIMEOUT_EN.
module mult_seq_ctrl #(
  parameter int SETTLE   = 2,
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [31:0] mul_result,
  input  logic        mul_valid,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [15:0] hi,
  output logic [15:0] lo,
  output logic        error
);
`ifdef MULT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic neg, accept, hit, tmo;
  assign accept = start & (state != WAIT);
  // mul_valid is only trusted once SETTLE cycles have passed, hiding a stale flag from the previous product
  assign hit = (state == WAIT) & mul_valid & (cnt >= CNT_W'(SETTLE));
  assign tmo = TMO_EN & (state == WAIT) & ~mul_valid & (cnt == CNT_W'(MAX_WAIT));
  assign stall = (state == WAIT) | accept;
  always_comb begin
    nxt = accept ? WAIT : (hit | tmo) ? DONE : (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mul_a <= '0;
      mul_b <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= nxt;
      busy  <= nxt == WAIT;
      done  <= hit | tmo;
      error <= tmo;
      if (accept) begin
        mul_a <= (is_signed & op_a[15]) ? 16'(-op_a) : op_a;
        mul_b <= (is_signed & op_b[15]) ? 16'(-op_b) : op_b;
        neg   <= is_signed & (op_a[15] ^ op_b[15]);
        cnt   <= '0;
      end else if (state == WAIT && cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (hit)
        {hi, lo} <= neg ? 32'(-mul_result) : mul_result;
      else if (tmo)
        {hi, lo} <= '0;
    end
  end
endmodule
